// File: rtl/krasin_tt02_spi_pwm_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : krasin_spi_pwm_pkg
// Description : Shared constants and FSM state type for the SPI PWM command rx.
// Revision    : 1.0
// ============================================================================
package krasin_spi_pwm_pkg;

    localparam logic [1:0] OP_SET     = 2'b10;
    localparam int         FRAME_BITS = 8;
    localparam logic [3:0] ERR_MAX    = 4'd15;
    localparam logic [3:0] BITCNT_SAT = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/krasin_tt02_spi_pwm_cmd_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-stage synchronizer with history flop and registered
//               rise/fall pulses.
// Revision    : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_rise;
    logic                   r_fall;

    // Everything resets low so a pin held high at reset yields only a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_hist;
        end
    end

    assign o_level_s = r_sync[SYNC_STAGES-1];
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;

endmodule
`default_nettype wire

// File: rtl/krasin_tt02_spi_pwm_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : krasin_tt02_spi_pwm_cmd_rx
// Description : Mode-0 SPI slave that turns 8-bit SET frames into PWM
//               set-channel strobes and counts rejected frames.
// Revision    : 1.0
// ============================================================================
module krasin_tt02_spi_pwm_cmd_rx
    import krasin_spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_pset,
    output logic [2:0] o_addr,
    output logic [2:0] o_level,
    output logic [3:0] o_err_cnt,
    output logic       o_busy
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_shreg;
    logic [3:0] r_bitcnt;
    logic [3:0] r_err_cnt;
    logic [2:0] r_addr;
    logic [2:0] r_level;

    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi_s;
    logic w_frame_ok;
    logic w_sclk_lvl_unused;
    logic w_sclk_fall_unused;
    logic w_cs_lvl_unused;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_d       (i_sclk),
        .o_level_s (w_sclk_lvl_unused),
        .o_rise    (w_sclk_rise),
        .o_fall    (w_sclk_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_d       (i_cs_n),
        .o_level_s (w_cs_lvl_unused),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_d       (i_mosi),
        .o_level_s (w_mosi_s),
        .o_rise    (w_mosi_rise_unused),
        .o_fall    (w_mosi_fall_unused)
    );

    assign w_frame_ok = (r_bitcnt == 4'(FRAME_BITS)) && (r_shreg[7:6] == OP_SET);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_next = w_frame_ok ? COMMIT : IDLE;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_pset = (r_state == COMMIT);
        o_busy = (r_state != IDLE);
    end

    // A cs_n rise takes priority: a coincident sclk edge is not shifted in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_err_cnt <= '0;
            r_addr    <= '0;
            r_level   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_shreg  <= '0;
                        r_bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        if (w_frame_ok) begin
                            r_addr  <= r_shreg[5:3];
                            r_level <= r_shreg[2:0];
                        end else if (r_err_cnt != ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + 4'd1;
                        end
                    end else if (w_sclk_rise) begin
                        r_shreg <= {r_shreg[6:0], w_mosi_s};
                        if (r_bitcnt != BITCNT_SAT) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_addr    = r_addr;
    assign o_level   = r_level;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_krasin_tt02_spi_pwm_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_krasin_tt02_spi_pwm_cmd_rx
// Description : Randomized self-checking bench with a frame-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_krasin_tt02_spi_pwm_cmd_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       pset;
    logic [2:0] addr;
    logic [2:0] level;
    logic [3:0] err_cnt;
    logic       busy;

    krasin_tt02_spi_pwm_cmd_rx #(.SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sclk    (sclk),
        .i_cs_n    (cs_n),
        .i_mosi    (mosi),
        .o_pset    (pset),
        .o_addr    (addr),
        .o_level   (level),
        .o_err_cnt (err_cnt),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] l;
        int         c;
    } ev_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    ev_t        got_q[$];
    logic [5:0] exp_q[$];
    int         exp_err = 0;
    logic [2:0] exp_addr = 3'd0;
    logic [2:0] exp_level = 3'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every pset pulse with the outputs seen in that cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pset === 1'b1) got_q.push_back('{addr, level, cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sbit(input logic b);
        mosi = b;
        tick(4);
        sclk = 1'b1;
        tick(3);
        sclk = 1'b0;
    endtask

    // Frame-level rule: exactly 8 counted bits with opcode 10 commits, else one error.
    task automatic model_frame(input logic [15:0] bits, input int n, input bit coin);
        int          cnt;
        logic [15:0] sh;
        cnt = coin ? n - 1 : n;
        sh  = bits >> (n - cnt);
        if (cnt == 8 && sh[7:6] == 2'b10) begin
            exp_q.push_back(sh[5:0]);
            exp_addr  = sh[5:3];
            exp_level = sh[2:0];
        end else if (exp_err < 15) begin
            exp_err++;
        end
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n, input bit coin, input int gap);
        model_frame(bits, n, coin);
        cs_n = 1'b0;
        tick(5);
        chk("busy_mid", busy, 1);
        for (int i = n - 1; i >= 0; i--) begin
            if (coin && i == 0) begin
                mosi = bits[i];
                tick(4);
                sclk = 1'b1;
                cs_n = 1'b1;
                rise_cyc = cyc;
                tick(3);
                sclk = 1'b0;
            end else begin
                sbit(bits[i]);
            end
        end
        if (!coin) begin
            tick(2);
            cs_n = 1'b1;
            rise_cyc = cyc;
        end
        tick(gap);
    endtask

    task automatic check_group(input string tag);
        tick(10);
        chk({tag, "_npset"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_addr_ev"}, got_q[i].a, exp_q[i][5:3]);
            chk({tag, "_level_ev"}, got_q[i].l, exp_q[i][2:0]);
        end
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_addr"}, addr, exp_addr);
        chk({tag, "_level"}, level, exp_level);
        chk({tag, "_busy"}, busy, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] rb;
        int          rn;

        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        tick(3);
        chk("rst_pset", pset, 0);
        chk("rst_addr", addr, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_npset", got_q.size(), 0);

        send_frame(16'h009D, 8, 1'b0, 8);
        chk("t1_npset_raw", got_q.size(), 1);
        if (got_q.size() > 0) chk("t1_latency", got_q[0].c - rise_cyc, 4);
        check_group("t1");

        for (int i = 0; i < 8; i++) begin
            send_frame(16'(8'h80 | (i << 3) | (7 - i)), 8, 1'b0, 3);
        end
        check_group("b2b");

        send_frame(16'h004E, 7, 1'b0, 4);
        send_frame(16'h013B, 9, 1'b0, 4);
        send_frame(16'h005D, 8, 1'b0, 4);
        check_group("rej");

        send_frame(16'h013A, 9, 1'b1, 4);
        check_group("coin");

        // Reset in the middle of 0x9D with cs_n held low through release.
        cs_n = 1'b0;
        tick(5);
        sbit(1'b1); sbit(1'b0); sbit(1'b0); sbit(1'b1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sbit(1'b1); sbit(1'b1); sbit(1'b0); sbit(1'b1);
        tick(2);
        cs_n = 1'b1;
        tick(4);
        exp_err   = 0;
        exp_addr  = 3'd0;
        exp_level = 3'd0;
        exp_q.delete();
        check_group("midrst");

        send_frame(16'h00BF, 8, 1'b0, 4);
        check_group("bf");

        for (int g = 0; g < 3; g++) begin
            repeat (10) begin
                rn = $urandom_range(6, 10);
                rb = 16'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    rn = 8;
                    rb[7:6] = 2'b10;
                end
                send_frame(rb, rn, 1'b0, $urandom_range(3, 6));
            end
            check_group("rnd");
        end

        repeat (20) send_frame(16'h005D, 8, 1'b0, 3);
        check_group("sat");
        chk("sat_err_15", err_cnt, 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
